// File: rtl/ahb_default_slave_p.sv
// AHB-Lite default slave: zero-wait OKAY for IDLE/BUSY, two-cycle ERROR for
// NONSEQ/SEQ (optionally preceded by wait states), plus error diagnostics.
module ahb_default_slave_p #(
    parameter int unsigned           DATA_WIDTH = 64,
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           CNT_WIDTH  = 8,
    parameter int unsigned           ERR_WAIT   = 0,
    parameter logic [DATA_WIDTH-1:0] RDATA_FILL = '1
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  HSEL,
    input  logic                  HREADY,
    input  logic [1:0]            HTRANS,
    input  logic                  HWRITE,
    input  logic [ADDR_WIDTH-1:0] HADDR,
    input  logic [DATA_WIDTH-1:0] HWDATA,
    output logic                  HREADYOUT,
    output logic                  HRESP,
    output logic [DATA_WIDTH-1:0] HRDATA,
    input  logic                  ERR_CLR,
    output logic [CNT_WIDTH-1:0]  ERR_COUNT,
    output logic [ADDR_WIDTH-1:0] ERR_ADDR,
    output logic                  ERR_WRITE,
    output logic                  ERR_IRQ
);

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StWait = 2'b01,
        StErr1 = 2'b10,
        StErr2 = 2'b11
    } state_e;

    localparam logic [3:0] WaitInit = 4'(ERR_WAIT);
    localparam bit         HasWait  = (ERR_WAIT != 0);

    state_e                state_q, state_d;
    logic [3:0]            wait_q, wait_d;
    logic                  hreadyout_q, hresp_q, irq_q;
    logic [CNT_WIDTH-1:0]  cnt_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  write_q;
    logic                  valid;
    logic                  capture;
    logic                  err_done;

    // Write data and the SEQ/NONSEQ distinction carry no information here.
    logic unused_inputs;
    assign unused_inputs = ^{HWDATA, HTRANS[0]};

    assign valid    = HSEL & HREADY & HTRANS[1];
    // A new address phase is only accepted while the slave is ready.
    assign capture  = valid & ((state_q == StIdle) | (state_q == StErr2));
    assign err_done = (state_q == StErr2);

    // Next-state and wait-counter decode.
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        unique case (state_q)
            StIdle, StErr2: begin
                if (valid) begin
                    if (HasWait) begin
                        state_d = StWait;
                        wait_d  = WaitInit;
                    end else begin
                        state_d = StErr1;
                    end
                end else begin
                    state_d = StIdle;
                end
            end
            StWait: begin
                wait_d = wait_q - 4'd1;
                // <= guards against a stuck counter should it ever read zero.
                if (wait_q <= 4'd1) begin
                    state_d = StErr1;
                    wait_d  = 4'd0;
                end
            end
            StErr1: state_d = StErr2;
            default: state_d = StIdle;
        endcase
    end

    // State register with Moore outputs registered from the next state.
    always_ff @(posedge HCLK or negedge HRESET) begin
        if (!HRESET) begin
            state_q     <= StIdle;
            wait_q      <= 4'd0;
            hreadyout_q <= 1'b1;
            hresp_q     <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            hreadyout_q <= (state_d == StIdle) | (state_d == StErr2);
            hresp_q     <= (state_d == StErr1) | (state_d == StErr2);
            irq_q       <= (state_d == StErr2);
        end
    end

    // Diagnostics: saturating error count and last faulting address/direction.
    always_ff @(posedge HCLK or negedge HRESET) begin
        if (!HRESET) begin
            cnt_q   <= '0;
            addr_q  <= '0;
            write_q <= 1'b0;
        end else begin
            if (ERR_CLR) begin
                // A clear coinciding with a completed error keeps that error.
                cnt_q <= err_done ? CNT_WIDTH'(1) : '0;
            end else if (err_done && (cnt_q != '1)) begin
                cnt_q <= cnt_q + CNT_WIDTH'(1);
            end
            if (capture) begin
                addr_q  <= HADDR;
                write_q <= HWRITE;
            end
        end
    end

    assign HREADYOUT = hreadyout_q;
    assign HRESP     = hresp_q;
    assign HRDATA    = RDATA_FILL;
    assign ERR_COUNT = cnt_q;
    assign ERR_ADDR  = addr_q;
    assign ERR_WRITE = write_q;
    assign ERR_IRQ   = irq_q;

endmodule
